// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared MIPS datapath.
// The master side is the controller: it reads IR/flags and drives the control set.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic             MemRead;
  logic             ExtOp;
  logic             ALUSrc;
  logic             RegDst;
  logic             MemtoReg;
  logic [1:0]       nPC_sel;
  logic [2:0]       ALUctr;
  logic             ExtHigh;
  logic             JAL_PC;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemWrite, MemRead, ExtOp, ALUSrc, RegDst,
           MemtoReg, nPC_sel, ALUctr, ExtHigh, JAL_PC, illegal, state, instret
  );

  modport slave (
    output instr, zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemWrite, MemRead, ExtOp, ALUSrc, RegDst,
           MemtoReg, nPC_sel, ALUctr, ExtHigh, JAL_PC, illegal, state, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared MIPS datapath: 3 cycles (beq/jr/jal), 4 (ALU ops, sw),
// 5 (lw), plus one per MEM cycle with mem_ready low; all outputs decode from state and IR.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_JR    = 6'h08;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  logic [5:0] op, fn;
  logic       is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal;
  logic       unused_instr;

  assign op = bus.instr[31:26];
  assign fn = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];

  assign is_add = (op == OP_RTYPE) && (fn == FN_ADD);
  assign is_sub = (op == OP_RTYPE) && (fn == FN_SUB);
  assign is_jr  = (op == OP_RTYPE) && (fn == FN_JR);
  assign is_ori = (op == OP_ORI);
  assign is_lui = (op == OP_LUI);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_jal = (op == OP_JAL);

  logic       pc_write, ir_write, reg_write, mem_write, mem_read;
  logic       ext_op, alu_src, reg_dst, mem_to_reg, ext_high, jal_pc, illegal;
  logic [1:0] npc_sel;
  logic [2:0] alu_ctr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = FETCH;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    npc_sel    = 2'd0;
    alu_ctr    = 3'd0;
    ext_high   = 1'b0;
    jal_pc     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = DECODE;
      end
      DECODE: begin
        if (is_jal) begin
          state_d = WB;
        end else if (is_add || is_sub || is_ori || is_lui || is_lw || is_sw || is_beq || is_jr) begin
          state_d = EXEC;
        end else begin
          illegal = 1'b1;
        end
      end
      EXEC: begin
        if (is_add) begin
          reg_dst = 1'b1;
          state_d = WB;
        end else if (is_sub) begin
          alu_ctr = 3'd1;
          reg_dst = 1'b1;
          state_d = WB;
        end else if (is_ori) begin
          alu_src = 1'b1;
          alu_ctr = 3'd2;
          state_d = WB;
        end else if (is_lui) begin
          alu_src  = 1'b1;
          ext_high = 1'b1;
          state_d  = WB;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
          ext_op  = 1'b1;
          state_d = MEM;
        end else if (is_beq) begin
          alu_ctr  = 3'd1;
          npc_sel  = 2'd1;
          pc_write = bus.zero;
          retire   = 1'b1;
        end else if (is_jr) begin
          npc_sel  = 2'd3;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      MEM: begin
        // Address operands stay on the ALU so the memory sees a stable address while waiting.
        alu_src   = 1'b1;
        ext_op    = 1'b1;
        mem_read  = is_lw;
        mem_write = is_sw;
        if (!bus.mem_ready) begin
          state_d = MEM;
        end else if (is_lw) begin
          state_d = WB;
        end else begin
          retire = is_sw;
        end
      end
      WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (is_add || is_sub) begin
          reg_dst = 1'b1;
        end else if (is_lw) begin
          mem_to_reg = 1'b1;
        end else if (is_ori) begin
          alu_src = 1'b1;
          alu_ctr = 3'd2;
        end else if (is_lui) begin
          alu_src  = 1'b1;
          ext_high = 1'b1;
        end else if (is_jal) begin
          jal_pc   = 1'b1;
          pc_write = 1'b1;
          npc_sel  = 2'd2;
        end
      end
      default: state_d = FETCH;
    endcase

    // State snaps to FETCH asynchronously, so gate the FETCH enables while reset is held.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      ext_op     = 1'b0;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      npc_sel    = 2'd0;
      alu_ctr    = 3'd0;
      ext_high   = 1'b0;
      jal_pc     = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign bus.PCWrite  = pc_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegWrite = reg_write;
  assign bus.MemWrite = mem_write;
  assign bus.MemRead  = mem_read;
  assign bus.ExtOp    = ext_op;
  assign bus.ALUSrc   = alu_src;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.nPC_sel  = npc_sel;
  assign bus.ALUctr   = alu_ctr;
  assign bus.ExtHigh  = ext_high;
  assign bus.JAL_PC   = jal_pc;
  assign bus.illegal  = illegal;
  assign bus.state    = state_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its expected
// per-cycle trace and compared cycle by cycle, directed cases first then random mix.
module tb_multicycle_controller;
  localparam int CNT_W = 4;

  localparam int K_ADD = 0, K_SUB = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_JR = 7, K_JAL = 8, K_BAD = 9;

  typedef struct packed {
    logic       pcw, irw, rw, mw, mr, ext, alusrc, regdst, m2r;
    logic [1:0] npc;
    logic [2:0] aluctr;
    logic       exth, jal, ill;
  } ctl_t;

  typedef struct {
    logic [2:0] st;
    ctl_t       c;
    logic       mr_in;
    logic       z_in;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(CNT_W)) bus();
  multicycle_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  ctl_t obs_ctl;
  assign obs_ctl = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead,
                    bus.ExtOp, bus.ALUSrc, bus.RegDst, bus.MemtoReg, bus.nPC_sel,
                    bus.ALUctr, bus.ExtHigh, bus.JAL_PC, bus.illegal};

  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] exp_instret;
  rec_t             exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    case (op)
      6'h00:   return (fn == 6'h20) ? K_ADD : (fn == 6'h22) ? K_SUB : (fn == 6'h08) ? K_JR : K_BAD;
      6'h0d:   return K_ORI;
      6'h0f:   return K_LUI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h03:   return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [31:0] make_instr(input int k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADD: begin r[31:26] = 6'h00; r[5:0] = 6'h20; end
      K_SUB: begin r[31:26] = 6'h00; r[5:0] = 6'h22; end
      K_JR:  begin r[31:26] = 6'h00; r[5:0] = 6'h08; end
      K_ORI: r[31:26] = 6'h0d;
      K_LUI: r[31:26] = 6'h0f;
      K_LW:  r[31:26] = 6'h23;
      K_SW:  r[31:26] = 6'h2b;
      K_BEQ: r[31:26] = 6'h04;
      K_JAL: r[31:26] = 6'h03;
      default: begin
        for (int t = 0; t < 100; t++) begin
          r = $urandom;
          if ($urandom_range(1) == 1) r[31:26] = 6'h00;
          if (kind_of(r) == K_BAD) return r;
        end
        r = 32'hfc00_0000;
      end
    endcase
    return r;
  endfunction

  function automatic void push(input logic [2:0] st, input ctl_t c, input logic mr_in, input logic z_in);
    rec_t r;
    r.st = st;
    r.c = c;
    r.mr_in = mr_in;
    r.z_in = z_in;
    exp_q.push_back(r);
  endfunction

  // Expected trace of one instruction: FETCH, DECODE, then the phases that instruction needs.
  function automatic void build(input int k, input int w, input logic z);
    ctl_t c;
    exp_q.delete();
    c = '0; c.pcw = 1; c.irw = 1;
    push(3'd0, c, 1'($urandom), 1'($urandom));
    c = '0; c.ill = (k == K_BAD);
    push(3'd1, c, 1'($urandom), 1'($urandom));
    if (k == K_BAD) return;
    if (k == K_JAL) begin
      c = '0; c.rw = 1; c.jal = 1; c.pcw = 1; c.npc = 2'd2;
      push(3'd4, c, 1'($urandom), 1'($urandom));
      return;
    end
    c = '0;
    case (k)
      K_ADD: c.regdst = 1;
      K_SUB: begin c.aluctr = 3'd1; c.regdst = 1; end
      K_ORI: begin c.alusrc = 1; c.aluctr = 3'd2; end
      K_LUI: begin c.alusrc = 1; c.exth = 1; end
      K_LW, K_SW: begin c.alusrc = 1; c.ext = 1; end
      K_BEQ: begin c.aluctr = 3'd1; c.npc = 2'd1; c.pcw = z; end
      default: begin c.npc = 2'd3; c.pcw = 1; end
    endcase
    push(3'd2, c, 1'($urandom), z);
    if (k == K_BEQ || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      c = '0; c.alusrc = 1; c.ext = 1; c.mr = (k == K_LW); c.mw = (k == K_SW);
      for (int i = 0; i <= w; i++) push(3'd3, c, (i == w), 1'($urandom));
      if (k == K_SW) return;
    end
    c = '0; c.rw = 1;
    case (k)
      K_ADD, K_SUB: c.regdst = 1;
      K_LW:  c.m2r = 1;
      K_ORI: begin c.alusrc = 1; c.aluctr = 3'd2; end
      default: begin c.alusrc = 1; c.exth = 1; end
    endcase
    push(3'd4, c, 1'($urandom), 1'($urandom));
  endfunction

  // Called at a falling edge; leaves the bench at the falling edge of the next FETCH (+1).
  task automatic run_instr(input string tag, input logic [31:0] ins, input int w, input logic z,
                           input int abort_at);
    int k;
    rec_t r;
    k = kind_of(ins);
    build(k, w, z);
    bus.instr = ins;
    for (int n = 0; n < exp_q.size(); n++) begin
      r = exp_q[n];
      bus.mem_ready = r.mr_in;
      bus.zero = r.z_in;
      if (n == abort_at) begin
        reset = 1'b1;
        #1;
        check($sformatf("%s rst_memrw", tag), {62'd0, bus.MemRead, bus.MemWrite}, 64'd0);
        check($sformatf("%s rst_all", tag), {bus.state, obs_ctl, bus.instret}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_instret = '0;
        return;
      end
      #1;
      check($sformatf("%s c%0d", tag, n), {bus.state, obs_ctl, bus.instret},
            {r.st, r.c, exp_instret});
      @(negedge clk);
    end
    if (k != K_BAD) exp_instret++;
    #1;
    check($sformatf("%s end", tag), {bus.state, bus.instret}, {3'd0, exp_instret});
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.instr = 32'h0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    exp_instret = '0;
    #2;
    check("reset", {bus.state, obs_ctl, bus.instret}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr("add",    32'h0022_1820, 0, 1'b0, -1);
    run_instr("lw_w2",  make_instr(K_LW), 2, 1'b0, -1);
    run_instr("sw_w0",  make_instr(K_SW), 0, 1'b0, -1);
    run_instr("beq_z1", make_instr(K_BEQ), 0, 1'b1, -1);
    run_instr("beq_z0", make_instr(K_BEQ), 0, 1'b0, -1);
    run_instr("jal",    make_instr(K_JAL), 0, 1'b0, -1);
    run_instr("jr",     make_instr(K_JR), 0, 1'b0, -1);
    run_instr("ill_3f", 32'hfc00_0000, 0, 1'b0, -1);
    run_instr("ill_fn", 32'h0000_002a, 0, 1'b0, -1);
    run_instr("sub",    make_instr(K_SUB), 0, 1'b0, -1);
    run_instr("ori",    make_instr(K_ORI), 0, 1'b0, -1);
    run_instr("lui",    make_instr(K_LUI), 0, 1'b0, -1);
    run_instr("sw_w3",  make_instr(K_SW), 3, 1'b0, -1);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(K_BAD);
      run_instr($sformatf("rnd%0d", i), make_instr(k), $urandom_range(3), 1'($urandom), -1);
    end

    run_instr("lw_rst", make_instr(K_LW), 4, 1'b0, 4);
    run_instr("after1", make_instr(K_ADD), 0, 1'b0, -1);
    run_instr("sw_rst", make_instr(K_SW), 3, 1'b0, 3);
    run_instr("after2", make_instr(K_JAL), 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared MIPS datapath (single ALU, single register file, one data-memory port) over several cycles per instruction. It replaces the one-cycle combinational decode.
- Supports ori, lw, sw, beq, lui, jal, add, sub and jr. Emits the same datapath control set plus per-state write enables.
- Also provides a data-memory wait handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  current IR contents (datapath IR, loaded by IRWrite).
- zero  in  1  ALU equality flag, valid in EXEC.
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- RegWrite  out  1  register-file write enable.
- MemWrite  out  1  data-memory write strobe.
- MemRead  out  1  data-memory read request.
- ExtOp  out  1  1 = sign-extend, 0 = zero-extend.
- ALUSrc  out  1  1 = immediate operand B.
- RegDst  out  1  1 = rd, 0 = rt.
- MemtoReg  out  1  1 = write-back from memory.
- nPC_sel  out  2  0 = PC+4, 1 = branch, 2 = jal target, 3 = rs (jr).
- ALUctr  out  3  0 = add, 1 = sub, 2 = or.
- ExtHigh  out  1  lui immediate<<16.
- JAL_PC  out  1  write-back PC+4 to $31.
- illegal  out  1  one-cycle pulse when an unsupported opcode/funct is decoded.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset, asynchronous: state=FETCH and instret=0. While reset is high, all enables (PCWrite, IRWrite, RegWrite, MemWrite, MemRead) and illegal are 0. All mux selects are 0 while in reset.
- Outputs are decoded combinationally from state and instr[31:26]/instr[5:0]. The IR is stable from DECODE onward.
- Any output not listed for a state is 0.
- FETCH: IRWrite=1, PCWrite=1, nPC_sel=0. Next state is DECODE.
- DECODE: no enables.
  - jal goes to WB.
  - add/sub/ori/lui/lw/sw/beq/jr go to EXEC.
  - Unsupported encodings (including R-type with other funct) pulse illegal=1 and return to FETCH, treated as a NOP and not counted.
- EXEC, decoded per instruction:
  - add: ALUctr=0, RegDst=1. Next WB.
  - sub: ALUctr=1, RegDst=1. Next WB.
  - ori: ALUSrc=1, ALUctr=2, ExtOp=0. Next WB.
  - lui: ALUSrc=1, ExtHigh=1. Next WB.
  - lw/sw: ALUSrc=1, ExtOp=1, ALUctr=0. Next MEM.
  - beq: ALUctr=1, nPC_sel=1, PCWrite=zero. Retires and goes to FETCH. The branch target is relative to the already-incremented PC.
  - jr: nPC_sel=3, PCWrite=1. Retires and goes to FETCH.
- MEM: address operands are held as in EXEC.
  - lw: MemRead=1.
  - sw: MemWrite=1.
  - Stay in MEM while mem_ready=0, holding all outputs constant.
  - On mem_ready=1: lw goes to WB; sw retires and goes to FETCH. The write commits on that edge, exactly once.
- WB: RegWrite=1.
  - add/sub: RegDst=1.
  - lw: MemtoReg=1.
  - ori/lui: operands held as in EXEC.
  - jal: JAL_PC=1, PCWrite=1, nPC_sel=2.
  - Retire, then go to FETCH.
- Retirement: instret increments by 1 on the edge leaving the retiring state. It wraps modulo 2^CNT_W.
- Latency in cycles:
  - beq/jr/jal: 3.
  - add/sub/ori/lui: 4.
  - sw: 4+w.
  - lw: 5+w.
  - w is the number of MEM cycles with mem_ready=0.
- mem_ready is ignored outside MEM.
- Reset asserted mid-MEM drops MemWrite/MemRead immediately (asynchronous) and returns to FETCH. instret is cleared.
- Undefined state encodings (5..7) go to FETCH with all enables 0.

Test Plan:
- Reset, then add (op 000000, funct 100000): state sequence 0,1,2,4,0. RegWrite=1 with RegDst=1 only in WB. instret 0→1.
- lw with mem_ready low for 2 cycles: MEM held 3 cycles with MemRead=1. WB has MemtoReg=1. Total 7 cycles. instret +1.
- sw with mem_ready=1 immediately: MemWrite high for exactly 1 cycle. No WB state. Returns to FETCH after 4 cycles.
- beq with zero=1, then beq with zero=0: PCWrite=1 then PCWrite=0 in EXEC, nPC_sel=1 both times. Each takes 3 cycles and both retire.
- jal then jr: jal WB has RegWrite=1, JAL_PC=1, nPC_sel=2, PCWrite=1. jr EXEC has nPC_sel=3, PCWrite=1. instret +2.
- Opcode 111111: illegal=1 in DECODE for one cycle, return to FETCH, instret unchanged. Separately, reset pulsed while in MEM clears MemRead and MemWrite that cycle, and state=0.
